// File: rtl/alu_wb_regfile.sv
// Write-back register file: ALU/load commit arbitration, 1-entry load
// pending buffer, bypassed read ports and a busy-bit scoreboard.
module alu_wb_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    input  logic            alu_valid_i,
    input  logic [AW-1:0]   alu_rd_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            ld_valid_i,
    output logic            ld_ready_o,
    input  logic [AW-1:0]   ld_rd_i,
    input  logic [XLEN-1:0] ld_data_i,
    input  logic            issue_valid_i,
    input  logic [AW-1:0]   issue_rd_i,
    output logic            stall_o,
    output logic            pend_valid_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic            pend_valid_q, pend_valid_d;
    logic [AW-1:0]   pend_rd_q, pend_rd_d;
    logic [XLEN-1:0] pend_data_q, pend_data_d;

    logic            ld_acc;
    logic            cm_valid;
    logic            cm_we;
    logic [AW-1:0]   cm_rd;
    logic [XLEN-1:0] cm_data;
    logic            hit1, hit2;

    assign ld_ready_o   = !pend_valid_q;
    assign pend_valid_o = pend_valid_q;
    assign ld_acc       = ld_valid_i && ld_ready_o;

    // Single write port: ALU first, then the parked load, then a fresh load
    always_comb begin
        cm_valid = 1'b0;
        cm_rd    = '0;
        cm_data  = '0;
        if (alu_valid_i) begin
            cm_valid = 1'b1;
            cm_rd    = alu_rd_i;
            cm_data  = alu_result_i;
        end else if (pend_valid_q) begin
            cm_valid = 1'b1;
            cm_rd    = pend_rd_q;
            cm_data  = pend_data_q;
        end else if (ld_acc) begin
            cm_valid = 1'b1;
            cm_rd    = ld_rd_i;
            cm_data  = ld_data_i;
        end
    end

    assign cm_we = cm_valid && (cm_rd != '0);

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_rd_d    = pend_rd_q;
        pend_data_d  = pend_data_q;
        if (alu_valid_i && ld_acc) begin
            pend_valid_d = 1'b1;
            pend_rd_d    = ld_rd_i;
            pend_data_d  = ld_data_i;
        end else if (!alu_valid_i && pend_valid_q) begin
            pend_valid_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (cm_we) begin
            regs_d[cm_rd] = cm_data;
        end
    end

    // A newly issued writer owns the register even if an older one commits
    always_comb begin
        busy_d = busy_q;
        if (cm_valid) begin
            busy_d[cm_rd] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_rd_q    <= '0;
            pend_data_q  <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q       <= busy_d;
            pend_valid_q <= pend_valid_d;
            pend_rd_q    <= pend_rd_d;
            pend_data_q  <= pend_data_d;
        end
    end

    assign hit1 = cm_we && (cm_rd == rs1_addr_i);
    assign hit2 = cm_we && (cm_rd == rs2_addr_i);

    assign rs1_data_o = (rs1_addr_i == '0) ? '0 :
                        hit1 ? cm_data : regs_q[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == '0) ? '0 :
                        hit2 ? cm_data : regs_q[rs2_addr_i];

    assign stall_o = (busy_q[rs1_addr_i] && !hit1) ||
                     (busy_q[rs2_addr_i] && !hit2);

endmodule

// File: tb/tb_alu_wb_regfile.sv
// Testbench for alu_wb_regfile: directed vector table, reset sequences
// and randomized traffic against a behavioural model.
module tb_alu_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_data, rs2_data;
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_res;
    logic        ld_v, ld_rdy;
    logic [4:0]  ld_rd;
    logic [31:0] ld_dat;
    logic        iss_v;
    logic [4:0]  iss_rd;
    logic        stall, pend;

    alu_wb_regfile dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rs1_addr_i   (rs1),
        .rs2_addr_i   (rs2),
        .rs1_data_o   (rs1_data),
        .rs2_data_o   (rs2_data),
        .alu_valid_i  (alu_v),
        .alu_rd_i     (alu_rd),
        .alu_result_i (alu_res),
        .ld_valid_i   (ld_v),
        .ld_ready_o   (ld_rdy),
        .ld_rd_i      (ld_rd),
        .ld_data_i    (ld_dat),
        .issue_valid_i(iss_v),
        .issue_rd_i   (iss_rd),
        .stall_o      (stall),
        .pend_valid_o (pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        av;
        bit [4:0]  ard;
        bit [31:0] ares;
        bit        lv;
        bit [4:0]  lrd;
        bit [31:0] ldat;
        bit        iv;
        bit [4:0]  ird;
        bit [4:0]  r1;
        bit [4:0]  r2;
        bit [31:0] e1;
        bit [31:0] e2;
        bit        est;
        bit        erdy;
        bit        epnd;
    } vec_t;

    typedef struct {
        bit [4:0]  rd;
        bit [31:0] data;
    } ld_t;

    int nvec = 0;
    int nerr = 0;

    bit [31:0] m_reg [32];
    bit        m_busy [32];
    ld_t       m_pend [$];

    vec_t tab [23];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_pend.delete();
    endtask

    // Which write (if any) wins the port this cycle
    function automatic void m_commit(input vec_t v, output bit cv,
                                     output bit [4:0] crd,
                                     output bit [31:0] cd);
        cv  = 1'b0;
        crd = '0;
        cd  = '0;
        if (v.av) begin
            cv = 1'b1; crd = v.ard; cd = v.ares;
        end else if (m_pend.size() != 0) begin
            cv = 1'b1; crd = m_pend[0].rd; cd = m_pend[0].data;
        end else if (v.lv) begin
            cv = 1'b1; crd = v.lrd; cd = v.ldat;
        end
    endfunction

    function automatic bit [31:0] m_read(input vec_t v, input bit [4:0] a);
        bit cv; bit [4:0] crd; bit [31:0] cd;
        m_commit(v, cv, crd, cd);
        if (a == 0) return '0;
        if (cv && crd == a) return cd;
        return m_reg[a];
    endfunction

    function automatic bit m_stall_on(input vec_t v, input bit [4:0] a);
        bit cv; bit [4:0] crd; bit [31:0] cd;
        m_commit(v, cv, crd, cd);
        if (a == 0) return 1'b0;
        return m_busy[a] && !(cv && crd == a);
    endfunction

    function automatic vec_t m_expect(input vec_t v);
        vec_t e = v;
        e.e1   = m_read(v, v.r1);
        e.e2   = m_read(v, v.r2);
        e.est  = m_stall_on(v, v.r1) || m_stall_on(v, v.r2);
        e.erdy = (m_pend.size() == 0);
        e.epnd = (m_pend.size() != 0);
        return e;
    endfunction

    task automatic m_update(input vec_t v);
        bit cv; bit [4:0] crd; bit [31:0] cd;
        bit ready;
        ready = (m_pend.size() == 0);
        m_commit(v, cv, crd, cd);
        if (cv && crd != 0) m_reg[crd] = cd;
        if (cv) m_busy[crd] = 1'b0;
        if (v.iv && v.ird != 0) m_busy[v.ird] = 1'b1;
        if (!v.av && m_pend.size() != 0) void'(m_pend.pop_front());
        if (v.av && v.lv && ready) m_pend.push_back('{v.lrd, v.ldat});
    endtask

    task automatic drive(input vec_t v);
        alu_v   = v.av;  alu_rd = v.ard; alu_res = v.ares;
        ld_v    = v.lv;  ld_rd  = v.lrd; ld_dat  = v.ldat;
        iss_v   = v.iv;  iss_rd = v.ird;
        rs1     = v.r1;  rs2    = v.r2;
    endtask

    task automatic run_cycle(input vec_t v, input bit use_tab, input string tag);
        vec_t e;
        drive(v);
        @(negedge clk);
        e = use_tab ? v : m_expect(v);
        chk({tag, ".rs1"},   rs1_data, e.e1);
        chk({tag, ".rs2"},   rs2_data, e.e2);
        chk({tag, ".stall"}, {31'd0, stall},  {31'd0, e.est});
        chk({tag, ".ready"}, {31'd0, ld_rdy}, {31'd0, e.erdy});
        chk({tag, ".pend"},  {31'd0, pend},   {31'd0, e.epnd});
        @(posedge clk);
        m_update(v);
        #1;
    endtask

    function automatic vec_t idle();
        vec_t v = '{default: '0};
        return v;
    endfunction

    initial begin
        vec_t v;

        // av ard ares lv lrd ldat iv ird r1 r2 | e1 e2 est erdy epnd
        tab[0]  = '{1, 5,  32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 1, 0};
        tab[1]  = '{0, 0,  0,            0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1, 0};
        tab[2]  = '{1, 0,  32'h1234,     0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 1, 0};
        tab[3]  = '{0, 0,  0,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        tab[4]  = '{1, 3,  32'h11,       1, 3, 32'h22, 0, 0, 3, 0, 32'h11, 0, 0, 1, 0};
        tab[5]  = '{0, 0,  0,            0, 0, 0, 0, 0, 3, 3, 32'h22, 32'h22, 0, 0, 1};
        tab[6]  = '{0, 0,  0,            0, 0, 0, 0, 0, 3, 0, 32'h22, 0, 0, 1, 0};
        tab[7]  = '{1, 3,  32'h33,       1, 6, 32'h66, 0, 0, 6, 3, 0, 32'h33, 0, 1, 0};
        tab[8]  = '{1, 8,  32'h80,       0, 0, 0, 0, 0, 6, 3, 0, 32'h33, 0, 0, 1};
        tab[9]  = '{1, 9,  32'h90,       0, 0, 0, 0, 0, 6, 3, 0, 32'h33, 0, 0, 1};
        tab[10] = '{1, 10, 32'hA0,       0, 0, 0, 0, 0, 6, 3, 0, 32'h33, 0, 0, 1};
        tab[11] = '{1, 11, 32'hB0,       0, 0, 0, 0, 0, 6, 3, 0, 32'h33, 0, 0, 1};
        tab[12] = '{0, 0,  0,            0, 0, 0, 0, 0, 6, 3, 32'h66, 32'h33, 0, 0, 1};
        tab[13] = '{0, 0,  0,            0, 0, 0, 0, 0, 6, 3, 32'h66, 32'h33, 0, 1, 0};
        tab[14] = '{0, 0,  0,            0, 0, 0, 1, 7, 0, 7, 0, 0, 0, 1, 0};
        tab[15] = '{0, 0,  0,            0, 0, 0, 0, 0, 0, 7, 0, 0, 1, 1, 0};
        tab[16] = '{0, 0,  0,            1, 7, 32'h77, 0, 0, 0, 7, 0, 32'h77, 0, 1, 0};
        tab[17] = '{0, 0,  0,            0, 0, 0, 0, 0, 0, 7, 0, 32'h77, 0, 1, 0};
        tab[18] = '{1, 7,  32'h70,       0, 0, 0, 1, 7, 0, 7, 0, 32'h70, 0, 1, 0};
        tab[19] = '{0, 0,  0,            0, 0, 0, 0, 0, 0, 7, 0, 32'h70, 1, 1, 0};
        tab[20] = '{1, 7,  32'h71,       0, 0, 0, 0, 0, 7, 0, 32'h71, 0, 0, 1, 0};
        tab[21] = '{0, 0,  0,            0, 0, 0, 1, 0, 7, 0, 32'h71, 0, 0, 1, 0};
        tab[22] = '{0, 0,  0,            0, 0, 0, 0, 0, 0, 7, 0, 32'h71, 0, 1, 0};

        m_reset();
        drive(idle());
        @(posedge clk);
        #3 rst = 1'b1;
        for (int i = 1; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(32 - i);
            #1;
            chk("rst.rs1", rs1_data, 32'd0);
            chk("rst.rs2", rs2_data, 32'd0);
        end
        chk("rst.ready", {31'd0, ld_rdy}, 32'd1);
        chk("rst.stall", {31'd0, stall},  32'd0);
        chk("rst.pend",  {31'd0, pend},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            run_cycle(tab[i], 1'b1, $sformatf("tab%0d", i));
        end

        // Park a load for x9 behind ALU traffic with x9 marked busy
        v = idle();
        v.av = 1'b1; v.ard = 5'd2; v.ares = 32'h5;
        v.lv = 1'b1; v.lrd = 5'd9; v.ldat = 32'h99;
        v.iv = 1'b1; v.ird = 5'd9;
        v.r1 = 5'd9;
        run_cycle(v, 1'b0, "prep");
        v = idle();
        v.av = 1'b1; v.ard = 5'd2; v.ares = 32'h6;
        v.r1 = 5'd9;
        drive(v);
        #2;
        chk("prst.pend",  {31'd0, pend},   32'd1);
        chk("prst.stall", {31'd0, stall},  32'd1);
        chk("prst.ready", {31'd0, ld_rdy}, 32'd0);
        #1;
        rst   = 1'b1;
        alu_v = 1'b0;
        #1;
        chk("mrst.pend",  {31'd0, pend},   32'd0);
        chk("mrst.stall", {31'd0, stall},  32'd0);
        chk("mrst.rs1",   rs1_data,        32'd0);
        chk("mrst.ready", {31'd0, ld_rdy}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        @(posedge clk);
        #1;

        for (int n = 0; n < 400; n++) begin
            v = idle();
            v.av   = ($urandom_range(0, 99) < 55);
            v.ard  = 5'($urandom_range(0, 7));
            v.ares = $urandom();
            v.lv   = ($urandom_range(0, 99) < 45);
            v.lrd  = 5'($urandom_range(0, 7));
            v.ldat = $urandom();
            v.iv   = ($urandom_range(0, 99) < 30);
            v.ird  = 5'($urandom_range(0, 7));
            v.r1   = 5'($urandom_range(0, 7));
            v.r2   = 5'($urandom_range(0, 7));
            run_cycle(v, 1'b0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
